bcd_conv_scheduler: RTL

BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

---
 rtl/bcd_conv_scheduler_pkg.sv | 20 ++
 rtl/bcd_conv_scheduler_dabble.sv | 27 ++
 rtl/bcd_conv_scheduler.sv | 111 +++++++++++
 3 files changed

// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared constants, FSM state type and digit-correction constants for the
// round-robin binary-to-BCD conversion scheduler.
package bcd_conv_scheduler_pkg;

    localparam int N_REQ    = 4;
    localparam int BIN_W    = 8;
    localparam int BCD_W    = 12;
    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = BCD_W / DIGIT_W;

    localparam logic [DIGIT_W-1:0] DIGIT_THRESH = 4'd4;
    localparam logic [DIGIT_W-1:0] DIGIT_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_conv_scheduler_dabble.sv
// One combinational double-dabble iteration: correct every BCD digit above
// the threshold, then shift {digits, operand} left by one bit.
module bcd_dabble_step #(
    parameter int W = bcd_conv_scheduler_pkg::BIN_W
) (
    input  logic [bcd_conv_scheduler_pkg::BCD_W-1:0] digits,
    input  logic [W-1:0]                             operand,
    output logic [bcd_conv_scheduler_pkg::BCD_W-1:0] shifted_digits,
    output logic [W-1:0]                             shifted_operand
);
    import bcd_conv_scheduler_pkg::*;

    logic [BCD_W-1:0] corrected;

    // NOTE: default assignment first so no path through the loop leaves corrected unassigned (no latch).
    always_comb begin
        corrected = digits;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (digits[d*DIGIT_W +: DIGIT_W] > DIGIT_THRESH) begin
                corrected[d*DIGIT_W +: DIGIT_W] = digits[d*DIGIT_W +: DIGIT_W] + DIGIT_ADD;
            end
        end
    end

    assign {shifted_digits, shifted_operand} = {corrected, operand} << 1;

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin arbiter feeding a single sequential binary-to-BCD converter;
// one conversion in flight, result held until the consumer accepts it.
module bcd_conv_scheduler #(
    parameter int N_REQ = bcd_conv_scheduler_pkg::N_REQ,
    parameter int BIN_W = bcd_conv_scheduler_pkg::BIN_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_REQ-1:0]                         req_valid,
    input  logic [N_REQ*BIN_W-1:0]                   req_data,
    output logic [N_REQ-1:0]                         req_ready,
    output logic                                     res_valid,
    output logic [bcd_conv_scheduler_pkg::BCD_W-1:0] res_bcd,
    output logic [$clog2(N_REQ)-1:0]                 res_id,
    input  logic                                     res_ready,
    output logic                                     busy
);
    import bcd_conv_scheduler_pkg::*;

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BIN_W);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_found;
    logic [CNT_W-1:0] step_cnt;
    logic [BCD_W-1:0] digits;
    logic [BCD_W-1:0] digits_stepped;
    logic [BIN_W-1:0] operand;
    logic [BIN_W-1:0] operand_stepped;
    logic             accept;
    logic             last_step;

    bcd_dabble_step #(.W(BIN_W)) u_step (
        .digits          (digits),
        .operand         (operand),
        .shifted_digits  (digits_stepped),
        .shifted_operand (operand_stepped)
    );

    // First asserted request at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign accept    = (state == IDLE) && |(req_valid & req_ready);
    assign last_step = (step_cnt == CNT_W'(BIN_W - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: req_ready is gated by rst_n so no grant is visible while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst_n && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
        res_valid = (state == DONE);
        res_bcd   = (state == DONE) ? digits : '0;
        res_id    = id_q;
        busy      = (state != IDLE);
    end

    // NOTE: datapath is reset too, so an aborted conversion leaves no stale digits or owner id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            step_cnt <= '0;
            digits   <= '0;
            operand  <= '0;
        end else if (accept) begin
            operand  <= req_data[gnt_idx*BIN_W +: BIN_W];
            digits   <= '0;
            step_cnt <= '0;
            id_q     <= gnt_idx;
            rr_ptr   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (state == SHIFT) begin
            digits   <= digits_stepped;
            operand  <= operand_stepped;
            step_cnt <= step_cnt + 1'b1;
        end
    end

endmodule
